// File: rtl/debug_ram_sweeper_if.sv
// Host-stream and BRAM debug-port bundle for debug_ram_sweeper.
// Optional checksum signal present when SWEEPER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
interface debug_ram_sweeper_if #(
    parameter int unsigned WORDS = 4096
);
    localparam int unsigned CntW = $clog2(WORDS) + 1;

    logic            start;
    logic            mode;
    logic            busy;
    logic            done;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [31:0]     out_addr;
    logic [31:0]     dbg_a2;
    logic [31:0]     dbg_wd2;
    logic [3:0]      dbg_we2;
    logic [31:0]     dbg_rd2;
    logic [CntW-1:0] word_count;
`ifdef SWEEPER_CHECKSUM_EN
    logic [31:0]     checksum;

    modport master (
        input  start, mode, in_valid, in_data, in_last, out_ready, dbg_rd2,
        output busy, done, in_ready, out_valid, out_data, out_addr,
               dbg_a2, dbg_wd2, dbg_we2, word_count, checksum
    );
    modport slave (
        output start, mode, in_valid, in_data, in_last, out_ready, dbg_rd2,
        input  busy, done, in_ready, out_valid, out_data, out_addr,
               dbg_a2, dbg_wd2, dbg_we2, word_count, checksum
    );
`else
    modport master (
        input  start, mode, in_valid, in_data, in_last, out_ready, dbg_rd2,
        output busy, done, in_ready, out_valid, out_data, out_addr,
               dbg_a2, dbg_wd2, dbg_we2, word_count
    );
    modport slave (
        output start, mode, in_valid, in_data, in_last, out_ready, dbg_rd2,
        input  busy, done, in_ready, out_valid, out_data, out_addr,
               dbg_a2, dbg_wd2, dbg_we2, word_count
    );
`endif
endinterface

// File: rtl/debug_ram_sweeper.sv
// Loads a word stream into, or dumps a word range out of, a core RAM via its debug port.
// Define SWEEPER_CHECKSUM_EN to add a running modulo-2^32 checksum output.
`timescale 1ns/1ps
module debug_ram_sweeper #(
    parameter int unsigned WORDS  = 4096,
    parameter int unsigned RD_LAT = 1
) (
    input logic                 CPU_CLK,
    input logic                 CPU_RST,
    debug_ram_sweeper_if.master bus
);
    localparam int unsigned CntW = $clog2(WORDS) + 1;
    localparam int unsigned LatW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StDIssue, StDWait, StDOut, StDone} sweepState;

    sweepState       stateQ, stateD;
    logic [31:0]     pointerQ, pointerD;
    logic [CntW-1:0] countQ, countD;
    logic [LatW-1:0] latQ, latD;
    logic [31:0]     a2Q, a2D;
    logic [31:0]     wd2Q, wd2D;
    logic [3:0]      we2Q, we2D;
    logic [31:0]     outDataQ, outDataD;
    logic [31:0]     outAddrQ, outAddrD;
    logic            lastWord;
`ifdef SWEEPER_CHECKSUM_EN
    logic [31:0]     sumQ, sumD;
`endif

    assign lastWord = (countQ == CntW'(WORDS - 1));

    always_comb begin
        stateD   = stateQ;
        pointerD = pointerQ;
        countD   = countQ;
        latD     = latQ;
        a2D      = a2Q;
        wd2D     = wd2Q;
        we2D     = 4'b0000;
        outDataD = outDataQ;
        outAddrD = outAddrQ;
`ifdef SWEEPER_CHECKSUM_EN
        sumD     = sumQ;
`endif
        unique case (stateQ)
            StIdle: begin
                if (bus.start) begin
                    pointerD = '0;
                    countD   = '0;
`ifdef SWEEPER_CHECKSUM_EN
                    sumD     = '0;
`endif
                    if (bus.mode) begin
                        // Address is presented during D_ISSUE, so load it on entry.
                        a2D    = '0;
                        stateD = StDIssue;
                    end else begin
                        stateD = StLoad;
                    end
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    a2D      = pointerQ;
                    wd2D     = bus.in_data;
                    we2D     = 4'b1111;
                    pointerD = pointerQ + 32'd4;
                    countD   = countQ + CntW'(1);
`ifdef SWEEPER_CHECKSUM_EN
                    sumD     = sumQ + bus.in_data;
`endif
                    if (bus.in_last || lastWord) stateD = StDone;
                end
            end
            StDIssue: begin
                latD   = LatW'(RD_LAT);
                stateD = StDWait;
            end
            StDWait: begin
                latD = latQ - LatW'(1);
                if (latQ == LatW'(1)) begin
                    outDataD = bus.dbg_rd2;
                    outAddrD = pointerQ;
                    stateD   = StDOut;
                end
            end
            StDOut: begin
                if (bus.out_ready) begin
                    countD   = countQ + CntW'(1);
                    pointerD = pointerQ + 32'd4;
                    a2D      = pointerQ + 32'd4;
`ifdef SWEEPER_CHECKSUM_EN
                    sumD     = sumQ + outDataQ;
`endif
                    stateD   = lastWord ? StDone : StDIssue;
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            stateQ   <= StIdle;
            pointerQ <= '0;
            countQ   <= '0;
            latQ     <= '0;
            a2Q      <= '0;
            wd2Q     <= '0;
            we2Q     <= '0;
            outDataQ <= '0;
            outAddrQ <= '0;
`ifdef SWEEPER_CHECKSUM_EN
            sumQ     <= '0;
`endif
        end else begin
            stateQ   <= stateD;
            pointerQ <= pointerD;
            countQ   <= countD;
            latQ     <= latD;
            a2Q      <= a2D;
            wd2Q     <= wd2D;
            we2Q     <= we2D;
            outDataQ <= outDataD;
            outAddrQ <= outAddrD;
`ifdef SWEEPER_CHECKSUM_EN
            sumQ     <= sumD;
`endif
        end
    end

    assign bus.busy       = stateQ inside {StLoad, StDIssue, StDWait, StDOut};
    assign bus.done       = (stateQ == StDone);
    assign bus.in_ready   = (stateQ == StLoad);
    assign bus.out_valid  = (stateQ == StDOut);
    assign bus.out_data   = outDataQ;
    assign bus.out_addr   = outAddrQ;
    assign bus.dbg_a2     = a2Q;
    assign bus.dbg_wd2    = wd2Q;
    assign bus.dbg_we2    = we2Q;
    assign bus.word_count = countQ;
`ifdef SWEEPER_CHECKSUM_EN
    assign bus.checksum   = sumQ;
`endif
endmodule

// File: tb/tb_debug_ram_sweeper.sv
// Randomized bench for debug_ram_sweeper: RAM emulator, spec-level model checked every cycle.
`timescale 1ns/1ps
module tb_debug_ram_sweeper;
    localparam int unsigned WORDS  = 4096;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned AW     = $clog2(WORDS);

    logic CPU_CLK = 1'b0;
    logic CPU_RST = 1'b1;
    logic preloadReq = 1'b1;

    debug_ram_sweeper_if #(.WORDS(WORDS)) bus ();

    debug_ram_sweeper #(.WORDS(WORDS), .RD_LAT(RD_LAT)) dut (
        .CPU_CLK(CPU_CLK),
        .CPU_RST(CPU_RST),
        .bus    (bus)
    );

    initial forever #5 CPU_CLK = ~CPU_CLK;

    // Synchronous BRAM with RD_LAT cycles of read latency
    logic [31:0] ram [WORDS];
    logic [31:0] rdPipe [RD_LAT];
    always @(posedge CPU_CLK) begin
        if (preloadReq) begin
            for (int i = 0; i < int'(WORDS); i++) ram[i] <= 32'(i * 3);
        end else if (bus.dbg_we2 == 4'hF) begin
            ram[bus.dbg_a2[AW+1:2]] <= bus.dbg_wd2;
        end
        rdPipe[0] <= ram[bus.dbg_a2[AW+1:2]];
        for (int k = 1; k < int'(RD_LAT); k++) rdPipe[k] <= rdPipe[k-1];
    end
    assign bus.dbg_rd2 = rdPipe[RD_LAT-1];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: phase of operation, words transferred, pending write, invalid gap
    typedef enum {PhIdle, PhBusy, PhDone} phaseT;
    phaseT       ph = PhIdle;
    logic        mMode = 1'b0;
    int unsigned mCnt = 0;
    int unsigned mGap = 0;
    logic        wrPend = 1'b0;
    logic [31:0] wrAddr, wrData;
    logic [31:0] mSum = '0;
    logic [31:0] refMem [WORDS];
    logic [31:0] wrLogA [$];
    logic [31:0] wrLogD [$];
    int          doneSeen = 0;
    logic [31:0] lastHsAddr = '0;
    bit          run = 1'b0;

    initial begin
        logic expOv;
        for (int i = 0; i < int'(WORDS); i++) refMem[i] = 32'(i * 3);
        forever begin
            @(negedge CPU_CLK);
            if (CPU_RST) begin
                ph = PhIdle; mCnt = 0; wrPend = 1'b0; mSum = '0;
            end else if (run) begin
                check("busy", 32'(bus.busy), 32'(ph == PhBusy));
                check("done", 32'(bus.done), 32'(ph == PhDone));
                check("in_ready", 32'(bus.in_ready), 32'(ph == PhBusy && !mMode));
                expOv = (ph == PhBusy) && mMode && (mGap == 0);
                check("out_valid", 32'(bus.out_valid), 32'(expOv));
                if (expOv) begin
                    check("out_data", bus.out_data, refMem[mCnt]);
                    check("out_addr", bus.out_addr, 32'(mCnt * 4));
                end
                if (wrPend) begin
                    check("we2_write", 32'(bus.dbg_we2), 32'hF);
                    check("a2_write", bus.dbg_a2, wrAddr);
                    check("wd2_write", bus.dbg_wd2, wrData);
                    refMem[wrAddr[AW+1:2]] = wrData;
                    wrLogA.push_back(bus.dbg_a2);
                    wrLogD.push_back(bus.dbg_wd2);
                end else begin
                    check("we2_idle", 32'(bus.dbg_we2), 32'h0);
                end
                check("word_count", 32'(bus.word_count), 32'(mCnt));
`ifdef SWEEPER_CHECKSUM_EN
                if (ph != PhBusy) check("checksum", bus.checksum, mSum);
`endif
                if (bus.done) doneSeen++;
                wrPend = 1'b0;
                case (ph)
                    PhIdle: if (bus.start) begin
                        ph = PhBusy; mMode = bus.mode; mCnt = 0; mGap = RD_LAT + 1; mSum = '0;
                    end
                    PhBusy: begin
                        if (!mMode) begin
                            if (bus.in_valid) begin
                                wrPend = 1'b1; wrAddr = 32'(mCnt * 4); wrData = bus.in_data;
                                mSum = mSum + bus.in_data;
                                mCnt++;
                                if (bus.in_last || mCnt == WORDS) ph = PhDone;
                            end
                        end else if (mGap > 0) begin
                            mGap--;
                        end else if (bus.out_ready) begin
                            lastHsAddr = bus.out_addr;
                            mSum = mSum + refMem[mCnt];
                            mCnt++;
                            if (mCnt == WORDS) ph = PhDone;
                            else mGap = RD_LAT + 1;
                        end
                    end
                    default: ph = PhIdle;
                endcase
            end
        end
    end

    logic [31:0] ldQ [$];

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic startOp(input logic m);
        bus.start = 1'b1; bus.mode = m;
        tick();
        bus.start = 1'b0;
    endtask

    // Every offered word is taken on the next edge; the model flags any refusal.
    task automatic loadWords(input bit useLast, input bit spurious);
        int n = ldQ.size();
        for (int i = 0; i < n; i++) begin
            if (spurious && $urandom_range(3) == 0) begin
                bus.start = 1'b1; bus.mode = 1'($urandom_range(1));
                tick();
                bus.start = 1'b0;
            end
            if ($urandom_range(7) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    bus.in_data = $urandom; bus.in_last = 1'($urandom_range(1));
                    tick();
                end
            end
            bus.in_valid = 1'b1; bus.in_data = ldQ[i];
            bus.in_last = useLast && (i == n - 1);
            tick();
            bus.in_valid = 1'b0; bus.in_last = 1'b0;
        end
    endtask

    task automatic waitDone(input int budget, input string name);
        int k = 0;
        while (!bus.done && k < budget) begin tick(); k++; end
        if (!bus.done) begin
            checks++; failures++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end else begin
            tick();
        end
    endtask

    task automatic dumpAll(input int readyPct, input bit stallTest);
        int k = 0;
        int stalled = 0;
        int d0 = doneSeen;
        startOp(1'b1);
        while (!bus.done && k < 40 * int'(WORDS)) begin
            if (stallTest && bus.out_valid && mCnt == 2 && stalled < 5) begin
                bus.out_ready = 1'b0;
                stalled++;
                check("stall_data", bus.out_data, 32'd6);
                check("stall_addr", bus.out_addr, 32'h8);
            end else begin
                bus.out_ready = ($urandom_range(99) < 32'(readyPct));
            end
            bus.start = (k == 3 || k == 700);
            bus.mode  = 1'($urandom_range(1));
            tick(); k++;
        end
        bus.start = 1'b0; bus.out_ready = 1'b0;
        if (!bus.done) begin
            checks++; failures++;
            $display("FAIL dump_done: timeout after %0d cycles", k);
        end
        repeat (3) tick();
        check("dump_done_once", 32'(doneSeen - d0), 32'd1);
        check("dump_last_addr", lastHsAddr, 32'h3FFC);
        check("dump_word_count", 32'(bus.word_count), 32'd4096);
        if (stallTest) check("stall_cycles", 32'(stalled), 32'd5);
    endtask

    initial begin
        int base;
        bus.start = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge CPU_CLK);
        #1;
        preloadReq = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_we2", 32'(bus.dbg_we2), 32'h0);
        check("rst_a2", bus.dbg_a2, 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_word_count", 32'(bus.word_count), 32'h0);
        CPU_RST = 1'b0;
        run = 1'b1;
        tick();

        dumpAll(100, 1'b1);

        base = wrLogA.size();
        ldQ = '{32'h00000013, 32'h00100093, 32'hDEADBEEF};
        startOp(1'b0);
        loadWords(1'b1, 1'b0);
        check("load_done_pulse", 32'(bus.done), 32'h1);
        check("load_word_count", 32'(bus.word_count), 32'd3);
        tick(); tick();
        check("load_we2_after", 32'(bus.dbg_we2), 32'h0);
        check("load_nwrites", 32'(wrLogA.size() - base), 32'd3);
        if (wrLogA.size() - base == 3) begin
            check("load_a2_0", wrLogA[base], 32'h0);
            check("load_a2_1", wrLogA[base+1], 32'h4);
            check("load_a2_2", wrLogA[base+2], 32'h8);
            check("load_wd2_2", wrLogD[base+2], 32'hDEADBEEF);
        end

`ifdef SWEEPER_CHECKSUM_EN
        ldQ = '{32'hFFFFFFFF, 32'h00000002};
        startOp(1'b0);
        loadWords(1'b1, 1'b0);
        check("csum_wrap", bus.checksum, 32'h1);
        tick();
`endif

        // Asynchronous reset during a write cycle
        startOp(1'b0);
        bus.in_valid = 1'b1; bus.in_data = 32'hCAFE0001; bus.in_last = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("rst_mid_we2_pre", 32'(bus.dbg_we2), 32'hF);
        CPU_RST = 1'b1;
        #1;
        check("rst_mid_we2", 32'(bus.dbg_we2), 32'h0);
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'h0);
        repeat (2) tick();
        CPU_RST = 1'b0;
        tick();
        base = wrLogA.size();
        ldQ = '{32'h11111111, 32'h22222222};
        startOp(1'b0);
        loadWords(1'b1, 1'b0);
        tick();
        check("restart_nwrites", 32'(wrLogA.size() - base), 32'd2);
        if (wrLogA.size() - base == 2) begin
            check("restart_a2_0", wrLogA[base], 32'h0);
            check("restart_a2_1", wrLogA[base+1], 32'h4);
        end

        repeat (6) begin
            int n = $urandom_range(1, 12);
            ldQ = {};
            for (int i = 0; i < n; i++) ldQ.push_back($urandom);
            startOp(1'b0);
            loadWords(1'b1, 1'b1);
            waitDone(4, "rand_load_done");
            repeat ($urandom_range(0, 3)) tick();
        end

        // Full-depth load with no in_last: terminates on the WORDS-th word
        ldQ = {};
        for (int i = 0; i < int'(WORDS); i++) ldQ.push_back($urandom);
        startOp(1'b0);
        loadWords(1'b0, 1'b1);
        check("full_load_done", 32'(bus.done), 32'h1);
        check("full_load_count", 32'(bus.word_count), 32'd4096);
        tick();

        dumpAll(70, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
